// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Branch select codes produced by insdec
  typedef enum logic [1:0] {
    BS_SEQ  = 2'd0,
    BS_COND = 2'd1,
    BS_REG  = 2'd2,
    BS_JMP  = 2'd3
  } bs_e;

  // Opcode placed in IR whenever no real instruction is presented
  localparam logic [4:0] NOP_OP = 5'b00000;

  // Width of the branch offset / absolute target field in the instruction
  localparam int OFFS_W = 9;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction ROM bus: address/enable out of fetch, word back one cycle later.
interface fetch_unit_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 17
);
  logic [PC_W-1:0]  imem_addr;
  logic             imem_en;
  logic [INS_W-1:0] imem_rdata;

  modport master (output imem_addr, output imem_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_unit_branch_target_gen.sv
// Branch decision and target address for the instruction currently held in IR.
// Purely combinational; validity gating is applied by the caller.
module branch_target_gen
  import fetch_unit_pkg::*;
#(
  parameter int INS_W  = 17,
  parameter int PC_W   = 9,
  parameter int DATA_W = 16
) (
  input  logic [1:0]        bs,
  input  logic              ps,
  input  logic              zero_flag,
  input  logic [INS_W-1:0]  instr_out,
  input  logic [PC_W-1:0]   instr_pc,
  input  logic [DATA_W-1:0] a_bus,
  output logic              take,
  output logic [PC_W-1:0]   target
);

  logic signed [PC_W+OFFS_W-1:0] offs_sext;
  logic        [PC_W+OFFS_W-1:0] offs_zext;
  logic                          unused_hi_bits;

  assign offs_sext = {{PC_W{instr_out[OFFS_W-1]}}, instr_out[OFFS_W-1:0]};
  assign offs_zext = {{PC_W{1'b0}}, instr_out[OFFS_W-1:0]};

  // Opcode/register fields, upper A-bus bits and extension headroom never steer the PC
  assign unused_hi_bits = ^{instr_out[INS_W-1:OFFS_W], a_bus[DATA_W-1:PC_W],
                            offs_sext[PC_W+OFFS_W-1:PC_W], offs_zext[PC_W+OFFS_W-1:PC_W]};

  // Decode branch select into a take decision and a PC-width target (modulo 2^PC_W)
  always_comb begin
    take   = 1'b0;
    target = instr_pc + offs_sext[PC_W-1:0];
    case (bs_e'(bs))
      BS_COND: begin
        // ps=0 branches on zero, ps=1 on non-zero
        take   = zero_flag ^ ps;
        target = instr_pc + offs_sext[PC_W-1:0];
      end
      BS_REG: begin
        take   = 1'b1;
        target = a_bus[PC_W-1:0];
      end
      BS_JMP: begin
        take   = 1'b1;
        target = offs_zext[PC_W-1:0];
      end
      default: begin
        take = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, synchronous ROM addressing, IR toward insdec.
// Taken branches squash the fall-through word, costing one bubble.
// Optional build macro FETCH_PERF_EN adds saturating taken-branch / bubble counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              INS_W    = 17,
  parameter int              PC_W     = 9,
  parameter int              DATA_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic [1:0]        bs,
  input  logic              ps,
  input  logic              zero_flag,
  input  logic [DATA_W-1:0] a_bus,
  fetch_unit_if.master      imem,
  output logic [INS_W-1:0]  instr_out,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_taken,
  output logic [15:0]       perf_bubble
`endif
);

  localparam logic [INS_W-1:0] NOP_WORD = {NOP_OP, {(INS_W-5){1'b0}}};

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]  ipc_q, ipc_d;
  logic             vld_q, vld_d;

  logic             fetch_en;
  logic             take_evt;
  logic             bubble_evt;
  logic             bt_take;
  logic [PC_W-1:0]  bt_target;

  branch_target_gen #(
    .INS_W (INS_W),
    .PC_W  (PC_W),
    .DATA_W(DATA_W)
  ) u_btg (
    .bs       (bs),
    .ps       (ps),
    .zero_flag(zero_flag),
    .instr_out(ir_q),
    .instr_pc (ipc_q),
    .a_bus    (a_bus),
    .take     (bt_take),
    .target   (bt_target)
  );

  // Next-state, next-PC and IR load; stall leaves every register as is
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ipc_d      = ipc_q;
    vld_d      = vld_q;
    fetch_en   = 1'b0;
    take_evt   = 1'b0;
    bubble_evt = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_BOOT: begin
          // Prime the ROM with the word at pc; IR stays empty
          fetch_en   = 1'b1;
          ir_d       = NOP_WORD;
          vld_d      = 1'b0;
          bubble_evt = 1'b1;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          if (bt_take && vld_q) begin
            // Redirect and squash the fall-through word already in the ROM
            fetch_en   = 1'b1;
            pc_d       = bt_target;
            ir_d       = NOP_WORD;
            vld_d      = 1'b0;
            take_evt   = 1'b1;
            bubble_evt = 1'b1;
            if (halt_req) begin
              state_d = ST_HALT;
            end
          end else if (halt_req) begin
            // The word for pc is not issued; pc stays on it so BOOT refetches it
            ir_d    = NOP_WORD;
            vld_d   = 1'b0;
            state_d = ST_HALT;
          end else begin
            fetch_en = 1'b1;
            ir_d     = imem.imem_rdata;
            ipc_d    = pc_q;
            vld_d    = 1'b1;
            pc_d     = pc_q + PC_W'(1);
          end
        end
        ST_HALT: begin
          ir_d  = NOP_WORD;
          vld_d = 1'b0;
          if (resume) begin
            state_d = ST_BOOT;
          end
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // Control and pipeline registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
    end
  end

  assign imem.imem_addr = pc_d;
  assign imem.imem_en   = fetch_en;
  assign instr_out      = ir_q;
  assign instr_pc       = ipc_q;
  assign instr_valid    = vld_q;
  assign pc_out         = pc_q;
  assign halted         = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
  logic [15:0] perf_taken_q, perf_taken_d;
  logic [15:0] perf_bubble_q, perf_bubble_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Event counters; events are already qualified by !stall
  always_comb begin
    perf_taken_d  = take_evt   ? sat_inc16(perf_taken_q)  : perf_taken_q;
    perf_bubble_d = bubble_evt ? sat_inc16(perf_bubble_q) : perf_bubble_q;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_taken_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_taken_q  <= perf_taken_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_taken  = perf_taken_q;
  assign perf_bubble = perf_bubble_q;
`else
  logic unused_perf_evt;
  assign unused_perf_evt = take_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed branch vectors, multi-cycle corner sequences,
// and a randomized program checked against a program-order reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int INS_W  = 17;
  localparam int PC_W   = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;
  localparam logic [INS_W-1:0] NOP_EXP = 17'h00000;

  logic              clk = 1'b0;
  logic              rst, stall, halt_req, resume, ps, zero_flag;
  logic [1:0]        bs;
  logic [DATA_W-1:0] a_bus;
  logic [INS_W-1:0]  instr_out;
  logic [PC_W-1:0]   instr_pc, pc_out;
  logic              instr_valid, halted;
`ifdef FETCH_PERF_EN
  logic [15:0]       perf_taken, perf_bubble;
`endif

  fetch_unit_if #(.PC_W(PC_W), .INS_W(INS_W)) imem_bus ();

  fetch_unit #(.INS_W(INS_W), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt_req   (halt_req),
    .resume     (resume),
    .bs         (bs),
    .ps         (ps),
    .zero_flag  (zero_flag),
    .a_bus      (a_bus),
    .imem       (imem_bus),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_taken (perf_taken),
    .perf_bubble(perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  // Program ROM and per-address decoder answers (what insdec/ALU return for that word)
  logic [INS_W-1:0]  mem  [DEPTH];
  logic [1:0]        t_bs [DEPTH];
  logic              t_ps [DEPTH];
  logic              t_zf [DEPTH];
  logic [DATA_W-1:0] t_a  [DEPTH];

  always @(posedge clk) begin
    if (imem_bus.imem_en) imem_bus.imem_rdata <= mem[imem_bus.imem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decoder side: real answers for a valid IR, junk otherwise (must be ignored)
  task automatic drive_ctl();
    if (instr_valid) begin
      bs        = t_bs[instr_pc];
      ps        = t_ps[instr_pc];
      zero_flag = t_zf[instr_pc];
      a_bus     = t_a[instr_pc];
    end else begin
      bs        = 2'($urandom);
      ps        = 1'($urandom);
      zero_flag = 1'($urandom);
      a_bus     = 16'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_ctl();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = {8'(i) ^ 8'h5A, 9'(i)};
      t_bs[i] = 2'd0;
      t_ps[i] = 1'b0;
      t_zf[i] = 1'b0;
      t_a[i]  = 16'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_issue(input int addr, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1100; n++) begin
      if (instr_valid && (int'(instr_pc) == addr)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_issue: address never issued, got none, expected %0d", addr);
    end
  endtask

  // Reference model: what follows the instruction issued at address a
  function automatic bit model_take(input int a);
    case (t_bs[a])
      2'd1:    return (t_ps[a] == 1'b0) ? t_zf[a] : !t_zf[a];
      2'd2:    return 1'b1;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_target(input int a);
    int off;
    logic [INS_W-1:0] w;
    w   = mem[a];
    off = int'(w[8:0]);
    case (t_bs[a])
      2'd1: begin
        if (off >= 256) off = off - 512;
        return (a + off + DEPTH) % DEPTH;
      end
      2'd2:    return int'(t_a[a]) % DEPTH;
      default: return off;
    endcase
  endfunction

  typedef struct {
    int          at;
    logic [1:0]  vbs;
    logic        vps;
    logic        vzf;
    logic [15:0] va;
    logic [8:0]  off;
    bit          exp_take;
    int          exp_next;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit ok;
    int exp_pc;
    int exp_bub;
    int n;
    rst = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
    bs = 2'd0; ps = 1'b0; zero_flag = 1'b0; a_bus = '0;

    vecs[0] = '{4,  2'd1, 1'b0, 1'b1, 16'h0000, 9'h003, 1'b1, 7};
    vecs[1] = '{4,  2'd1, 1'b0, 1'b0, 16'h0000, 9'h003, 1'b0, 5};
    vecs[2] = '{10, 2'd1, 1'b1, 1'b0, 16'h0000, 9'h1FE, 1'b1, 8};
    vecs[3] = '{10, 2'd1, 1'b1, 1'b1, 16'h0000, 9'h1FE, 1'b0, 11};
    vecs[4] = '{6,  2'd2, 1'b0, 1'b0, 16'h0033, 9'h000, 1'b1, 51};
    vecs[5] = '{2,  2'd2, 1'b1, 1'b1, 16'hFE05, 9'h000, 1'b1, 5};
    vecs[6] = '{3,  2'd3, 1'b0, 1'b0, 16'h0000, 9'h1FF, 1'b1, 511};
    vecs[7] = '{5,  2'd0, 1'b0, 1'b1, 16'h0000, 9'h014, 1'b0, 6};
    vecs[8] = '{5,  2'd3, 1'b0, 1'b0, 16'h0000, 9'h014, 1'b1, 20};
    vecs[9] = '{7,  2'd1, 1'b0, 1'b1, 16'h0000, 9'h1F9, 1'b1, 0};

    // Reset values, BOOT bubble, then sequential issue
    clear_prog();
    rst = 1'b1;
    step();
    step();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr_out), 32'(NOP_EXP));
    check("rst_ipc", 32'(instr_pc), 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    step();
    check("boot_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("seq_valid", 32'(instr_valid), 32'd1);
      check("seq_ipc", 32'(instr_pc), 32'(i));
      check("seq_word", 32'(instr_out), 32'(mem[i]));
    end

    // Table of single-branch vectors
    foreach (vecs[k]) begin
      clear_prog();
      mem[vecs[k].at][8:0] = vecs[k].off;
      t_bs[vecs[k].at]     = vecs[k].vbs;
      t_ps[vecs[k].at]     = vecs[k].vps;
      t_zf[vecs[k].at]     = vecs[k].vzf;
      t_a[vecs[k].at]      = vecs[k].va;
      do_reset();
      wait_issue(vecs[k].at, ok);
      if (ok) begin
        step();
        if (vecs[k].exp_take) begin
          check("vec_bubble", 32'(instr_valid), 32'd0);
          step();
        end
        check("vec_valid", 32'(instr_valid), 32'd1);
        check("vec_next_ipc", 32'(instr_pc), 32'(vecs[k].exp_next));
        check("vec_next_word", 32'(instr_out), 32'(mem[vecs[k].exp_next]));
      end
    end

    // PC wrap from the top of the address space
    clear_prog();
    mem[3][8:0] = 9'h1FF;
    t_bs[3] = 2'd3;
    do_reset();
    wait_issue(511, ok);
    step();
    check("wrap_ipc", 32'(instr_pc), 32'd0);
    check("wrap_valid", 32'(instr_valid), 32'd1);
    check("wrap_pc", 32'(pc_out), 32'd1);

    // Three-cycle stall mid-stream
    clear_prog();
    do_reset();
    wait_issue(8, ok);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ipc", 32'(instr_pc), 32'd8);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", 32'(pc_out), 32'd9);
      check("stall_en", 32'(imem_bus.imem_en), 32'd0);
      check("stall_addr", 32'(imem_bus.imem_addr), 32'd9);
    end
    stall = 1'b0;
    step();
    check("unstall_ipc", 32'(instr_pc), 32'd9);
    check("unstall_word", 32'(instr_out), 32'(mem[9]));
    step();
    check("unstall_ipc2", 32'(instr_pc), 32'd10);

    // Halt together with a taken jump, then resume (with halt_req also high)
    clear_prog();
    mem[5][8:0] = 9'd20;
    t_bs[5] = 2'd3;
    do_reset();
    wait_issue(5, ok);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc_out), 32'd20);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_instr", 32'(instr_out), 32'(NOP_EXP));
    step();
    step();
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_hold_pc", 32'(pc_out), 32'd20);
    halt_req = 1'b1;
    resume = 1'b1;
    step();
    halt_req = 1'b0;
    resume = 1'b0;
    check("resume_flag", 32'(halted), 32'd0);
    n = 0;
    while (!instr_valid && n < 5) begin
      step();
      n++;
    end
    check("resume_ipc", 32'(instr_pc), 32'd20);
    check("resume_word", 32'(instr_out), 32'(mem[20]));

    // Halt on a sequential instruction: next word is not lost
    clear_prog();
    do_reset();
    wait_issue(7, ok);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_seq_flag", 32'(halted), 32'd1);
    check("halt_seq_pc", 32'(pc_out), 32'd8);
    resume = 1'b1;
    step();
    resume = 1'b0;
    n = 0;
    while (!instr_valid && n < 5) begin
      step();
      n++;
    end
    check("halt_seq_next", 32'(instr_pc), 32'd8);

    // Reset in the middle of the stream
    clear_prog();
    do_reset();
    wait_issue(6, ok);
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_pc", 32'(pc_out), 32'd0);
    check("midrst_ipc", 32'(instr_pc), 32'd0);
    rst = 1'b0;
    step();
    check("midrst_boot", 32'(instr_valid), 32'd0);
    step();
    check("midrst_first", 32'(instr_pc), 32'd0);

`ifdef FETCH_PERF_EN
    // Three taken branches after reset: 3 squashes plus the BOOT cycle
    clear_prog();
    mem[2][8:0] = 9'd8;   t_bs[2] = 2'd3;
    mem[8][8:0] = 9'd15;  t_bs[8] = 2'd3;
    mem[15][8:0] = 9'd5;  t_bs[15] = 2'd1; t_zf[15] = 1'b1;
    do_reset();
    check("perf_rst_taken", 32'(perf_taken), 32'd0);
    wait_issue(20, ok);
    check("perf_taken", 32'(perf_taken), 32'd3);
    check("perf_bubble", 32'(perf_bubble), 32'd4);
`endif

    // Randomized program against the program-order model
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      mem[i]  = 17'($urandom);
      t_bs[i] = (r < 7) ? 2'd0 : 2'(r - 6);
      t_ps[i] = 1'($urandom);
      t_zf[i] = 1'($urandom);
      t_a[i]  = 16'($urandom);
    end
    do_reset();
    exp_pc  = 0;
    exp_bub = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall = ($urandom_range(0, 4) == 0);
      if (!stall) begin
        if (exp_bub > 0) begin
          check("rand_bubble", 32'(instr_valid), 32'd0);
          exp_bub--;
        end else begin
          check("rand_valid", 32'(instr_valid), 32'd1);
          check("rand_ipc", 32'(instr_pc), 32'(exp_pc));
          check("rand_word", 32'(instr_out), 32'(mem[exp_pc]));
          if (model_take(exp_pc)) begin
            exp_pc  = model_target(exp_pc);
            exp_bub = 1;
          end else begin
            exp_pc = (exp_pc + 1) % DEPTH;
          end
        end
      end
      step();
    end
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
